// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Brief    : Registered MIPS-I conditional-branch resolution stage. It
//            evaluates BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ, computes the next PC,
//            sequences the wrong-path flush after a taken branch, and keeps
//            saturating branch statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int W            = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic [5:0]       op,
    input  logic [4:0]       rt_field,
    input  logic [W-1:0]     rs_data,
    input  logic [W-1:0]     rt_data,
    input  logic [W-1:0]     pc_plus4,
    input  logic [15:0]      imm,
    output logic             ready,
    output logic             out_valid,
    output logic             is_branch,
    output logic             taken,
    output logic [W-1:0]     target,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    // Opcode and REGIMM rt selectors of the supported branches
    localparam logic [5:0] c_OP_REGIMM = 6'd1;
    localparam logic [5:0] c_OP_BEQ    = 6'd4;
    localparam logic [5:0] c_OP_BNE    = 6'd5;
    localparam logic [5:0] c_OP_BLEZ   = 6'd6;
    localparam logic [5:0] c_OP_BGTZ   = 6'd7;
    localparam logic [4:0] c_RT_BLTZ   = 5'd0;
    localparam logic [4:0] c_RT_BGEZ   = 5'd1;

    // Flush sequencer states
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_FLUSH = 1'b1;

    // The flush down-counter only needs to hold FLUSH_CYCLES-1
    localparam int c_FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_FCNT_W-1:0] c_FCNT_LOAD = c_FCNT_W'(FLUSH_CYCLES - 1);

    logic [0:0]          r_state;
    logic [c_FCNT_W-1:0] r_fcnt;
    logic                r_out_valid;
    logic                r_is_branch;
    logic                r_taken;
    logic [W-1:0]        r_target;
    logic [CNT_W-1:0]    r_branch_cnt;
    logic [CNT_W-1:0]    r_taken_cnt;

    logic                w_ready;
    logic                w_accept;
    logic                w_is_branch;
    logic                w_taken;
    logic                w_rs_neg;
    logic                w_rs_zero;
    logic [W-1:0]        w_imm_ext;
    logic [W-1:0]        w_offset;
    logic [W-1:0]        w_target;

    // Acceptance depends only on stall and the sequencer state
    assign w_ready  = !stall && (r_state == c_ST_IDLE);
    assign w_accept = in_valid && w_ready;

    // Signed zero-compares reduce to the sign bit and a zero detect
    assign w_rs_neg  = rs_data[W-1];
    assign w_rs_zero = (rs_data == '0);

    // Word offset: sign-extend the 16-bit field, then scale by 4; wrap is silent
    assign w_imm_ext = {{(W-16){imm[15]}}, imm};
    assign w_offset  = w_imm_ext << 2;
    assign w_target  = w_taken ? (pc_plus4 + w_offset) : pc_plus4;

    // Branch decode and condition evaluation
    always_comb begin
        w_is_branch = 1'b0;
        w_taken     = 1'b0;
        case (op)
            c_OP_BEQ: begin
                w_is_branch = 1'b1;
                w_taken     = (rs_data == rt_data);
            end
            c_OP_BNE: begin
                w_is_branch = 1'b1;
                w_taken     = (rs_data != rt_data);
            end
            c_OP_BLEZ: begin
                w_is_branch = 1'b1;
                w_taken     = w_rs_neg || w_rs_zero;
            end
            c_OP_BGTZ: begin
                w_is_branch = 1'b1;
                w_taken     = !w_rs_neg && !w_rs_zero;
            end
            c_OP_REGIMM: begin
                if (rt_field == c_RT_BLTZ) begin
                    w_is_branch = 1'b1;
                    w_taken     = w_rs_neg;
                end else if (rt_field == c_RT_BGEZ) begin
                    w_is_branch = 1'b1;
                    w_taken     = !w_rs_neg;
                end
            end
            default: begin
                w_is_branch = 1'b0;
                w_taken     = 1'b0;
            end
        endcase
    end

    // Flush sequencer: a taken branch opens FLUSH_CYCLES unstalled flush cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_fcnt  <= '0;
        end else if (!stall) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept && w_taken) begin
                        r_state <= c_ST_FLUSH;
                        r_fcnt  <= c_FCNT_LOAD;
                    end
                end
                c_ST_FLUSH: begin
                    if (r_fcnt == '0) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_fcnt <= r_fcnt - c_FCNT_W'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_fcnt  <= '0;
                end
            endcase
        end
    end

    // Result registers: load on acceptance, otherwise drop the flags but keep target
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_is_branch <= 1'b0;
            r_taken     <= 1'b0;
            r_target    <= '0;
        end else if (!stall) begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_is_branch <= w_is_branch;
                r_taken     <= w_taken;
                r_target    <= w_target;
            end else begin
                r_out_valid <= 1'b0;
                r_is_branch <= 1'b0;
                r_taken     <= 1'b0;
            end
        end
    end

    // Statistics counters saturate at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else if (!stall && w_accept) begin
            if (w_is_branch && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_taken && (r_taken_cnt != '1)) begin
                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
        end
    end

    assign ready      = w_ready;
    assign out_valid  = r_out_valid;
    assign is_branch  = r_is_branch;
    assign taken      = r_taken;
    assign target     = r_target;
    assign flush      = (r_state == c_ST_FLUSH);
    assign branch_cnt = r_branch_cnt;
    assign taken_cnt  = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Brief    : Directed self-checking bench for branch_resolve_unit
//            (W=32, FLUSH_CYCLES=2, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int W     = 32;
    localparam int FC    = 2;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             stall;
    logic [5:0]       op;
    logic [4:0]       rt_field;
    logic [W-1:0]     rs_data;
    logic [W-1:0]     rt_data;
    logic [W-1:0]     pc_plus4;
    logic [15:0]      imm;
    logic             ready;
    logic             out_valid;
    logic             is_branch;
    logic             taken;
    logic [W-1:0]     target;
    logic             flush;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    int vectors;
    int miscompares;
    int exp_bc;
    int exp_tc;

    branch_resolve_unit #(
        .W            (W),
        .FLUSH_CYCLES (FC),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .stall      (stall),
        .op         (op),
        .rt_field   (rt_field),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .pc_plus4   (pc_plus4),
        .imm        (imm),
        .ready      (ready),
        .out_valid  (out_valid),
        .is_branch  (is_branch),
        .taken      (taken),
        .target     (target),
        .flush      (flush),
        .branch_cnt (branch_cnt),
        .taken_cnt  (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] o, input logic [4:0] rtf,
                         input logic [W-1:0] rs, input logic [W-1:0] rt,
                         input logic [W-1:0] pc, input logic [15:0] im);
        in_valid = v;
        op       = o;
        rt_field = rtf;
        rs_data  = rs;
        rt_data  = rt;
        pc_plus4 = pc;
        imm      = im;
    endtask

    // Saturating expectation for the 4-bit statistics counters
    function automatic int sat(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    // Zero-compare sweep table: op, rt_field, rs, expected taken
    logic [5:0]   sw_op  [12];
    logic [4:0]   sw_rtf [12];
    logic [W-1:0] sw_rs  [12];
    logic         sw_tk  [12];

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_bc      = 0;
        exp_tc      = 0;

        // rs = 0x80000000
        sw_op[0]  = 6'd6; sw_rtf[0]  = 5'd0; sw_rs[0]  = 32'h8000_0000; sw_tk[0]  = 1'b1;
        sw_op[1]  = 6'd7; sw_rtf[1]  = 5'd0; sw_rs[1]  = 32'h8000_0000; sw_tk[1]  = 1'b0;
        sw_op[2]  = 6'd1; sw_rtf[2]  = 5'd0; sw_rs[2]  = 32'h8000_0000; sw_tk[2]  = 1'b1;
        sw_op[3]  = 6'd1; sw_rtf[3]  = 5'd1; sw_rs[3]  = 32'h8000_0000; sw_tk[3]  = 1'b0;
        // rs = 0
        sw_op[4]  = 6'd6; sw_rtf[4]  = 5'd0; sw_rs[4]  = 32'h0;         sw_tk[4]  = 1'b1;
        sw_op[5]  = 6'd7; sw_rtf[5]  = 5'd0; sw_rs[5]  = 32'h0;         sw_tk[5]  = 1'b0;
        sw_op[6]  = 6'd1; sw_rtf[6]  = 5'd0; sw_rs[6]  = 32'h0;         sw_tk[6]  = 1'b0;
        sw_op[7]  = 6'd1; sw_rtf[7]  = 5'd1; sw_rs[7]  = 32'h0;         sw_tk[7]  = 1'b1;
        // rs = 1
        sw_op[8]  = 6'd6; sw_rtf[8]  = 5'd0; sw_rs[8]  = 32'h1;         sw_tk[8]  = 1'b0;
        sw_op[9]  = 6'd7; sw_rtf[9]  = 5'd0; sw_rs[9]  = 32'h1;         sw_tk[9]  = 1'b1;
        sw_op[10] = 6'd1; sw_rtf[10] = 5'd0; sw_rs[10] = 32'h1;         sw_tk[10] = 1'b0;
        sw_op[11] = 6'd1; sw_rtf[11] = 5'd1; sw_rs[11] = 32'h1;         sw_tk[11] = 1'b1;

        // ---------------- reset with stall and in_valid high ----------------
        rst   = 1'b1;
        stall = 1'b1;
        drive(1'b1, 6'd4, 5'd0, 32'h0, 32'h0, 32'h40, 16'h0001);
        tick();
        tick();
        rst   = 1'b0;
        stall = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_is_branch", is_branch, 0);
        chk("rst_taken", taken, 0);
        chk("rst_target", target, 0);
        chk("rst_flush", flush, 0);
        chk("rst_branch_cnt", branch_cnt, 0);
        chk("rst_taken_cnt", taken_cnt, 0);
        chk("rst_ready", ready, 1);

        // ---------------- BEQ taken, backward offset ----------------
        drive(1'b1, 6'd4, 5'd0, 32'd5, 32'd5, 32'h100, 16'hFFFE);
        tick();
        in_valid = 1'b0;
        exp_bc = sat(exp_bc); exp_tc = sat(exp_tc);
        chk("beq_valid", out_valid, 1);
        chk("beq_is_branch", is_branch, 1);
        chk("beq_taken", taken, 1);
        chk("beq_target", target, 32'hF8);
        chk("beq_flush1", flush, 1);
        chk("beq_ready1", ready, 0);
        chk("beq_bcnt", branch_cnt, exp_bc);
        chk("beq_tcnt", taken_cnt, exp_tc);
        tick();
        chk("beq_flush2", flush, 1);
        chk("beq_ready2", ready, 0);
        chk("beq_valid2", out_valid, 0);
        chk("beq_target_hold", target, 32'hF8);
        tick();
        chk("beq_flush_end", flush, 0);
        chk("beq_ready_end", ready, 1);

        // ---------------- BNE not taken ----------------
        drive(1'b1, 6'd5, 5'd0, 32'd7, 32'd7, 32'h200, 16'h0010);
        tick();
        in_valid = 1'b0;
        exp_bc = sat(exp_bc);
        chk("bne_valid", out_valid, 1);
        chk("bne_is_branch", is_branch, 1);
        chk("bne_taken", taken, 0);
        chk("bne_target", target, 32'h200);
        chk("bne_flush", flush, 0);
        chk("bne_ready", ready, 1);
        chk("bne_bcnt", branch_cnt, exp_bc);
        chk("bne_tcnt", taken_cnt, exp_tc);

        // ---------------- signed zero-compare sweep ----------------
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, sw_op[i], sw_rtf[i], sw_rs[i], 32'h0, 32'h1000, 16'h0004);
            tick();
            in_valid = 1'b0;
            exp_bc = sat(exp_bc);
            if (sw_tk[i]) exp_tc = sat(exp_tc);
            chk($sformatf("sweep%0d_is_branch", i), is_branch, 1);
            chk($sformatf("sweep%0d_taken", i), taken, sw_tk[i]);
            chk($sformatf("sweep%0d_target", i), target, sw_tk[i] ? 32'h1010 : 32'h1000);
            chk($sformatf("sweep%0d_flush", i), flush, sw_tk[i]);
            tick();
            tick();
        end
        chk("sweep_bcnt", branch_cnt, exp_bc);
        chk("sweep_tcnt", taken_cnt, exp_tc);

        // REGIMM with an unsupported rt selector is not a branch
        drive(1'b1, 6'd1, 5'd3, 32'h0, 32'h0, 32'h2000, 16'h0004);
        tick();
        in_valid = 1'b0;
        chk("regimm3_valid", out_valid, 1);
        chk("regimm3_is_branch", is_branch, 0);
        chk("regimm3_taken", taken, 0);
        chk("regimm3_target", target, 32'h2000);
        chk("regimm3_bcnt", branch_cnt, exp_bc);

        // ---------------- stall during flush ----------------
        drive(1'b1, 6'd4, 5'd0, 32'h0, 32'h0, 32'h300, 16'h0001);
        tick();
        in_valid = 1'b0;
        exp_bc = sat(exp_bc); exp_tc = sat(exp_tc);
        chk("stl_flush0", flush, 1);
        chk("stl_target0", target, 32'h304);
        stall    = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stl%0d_flush", i), flush, 1);
            chk($sformatf("stl%0d_valid", i), out_valid, 1);
            chk($sformatf("stl%0d_taken", i), taken, 1);
            chk($sformatf("stl%0d_target", i), target, 32'h304);
            chk($sformatf("stl%0d_ready", i), ready, 0);
            chk($sformatf("stl%0d_bcnt", i), branch_cnt, exp_bc);
        end
        stall = 1'b0;
        tick();
        chk("stl_flush_last", flush, 1);
        chk("stl_valid_last", out_valid, 0);
        chk("stl_bcnt_last", branch_cnt, exp_bc);
        tick();
        in_valid = 1'b0;
        chk("stl_flush_end", flush, 0);
        chk("stl_dropped_bcnt", branch_cnt, exp_bc);
        chk("stl_dropped_valid", out_valid, 0);

        // ---------------- target wrap-around ----------------
        drive(1'b1, 6'd4, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFC, 16'h0002);
        tick();
        in_valid = 1'b0;
        exp_bc = sat(exp_bc); exp_tc = sat(exp_tc);
        chk("wrap_target", target, 32'h0000_0004);
        chk("wrap_taken", taken, 1);
        tick();
        tick();

        // ---------------- counter saturation ----------------
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 6'd4, 5'd0, 32'h9, 32'h9, 32'h400, 16'h0001);
            tick();
            in_valid = 1'b0;
            tick();
            tick();
        end
        chk("sat_bcnt", branch_cnt, 15);
        chk("sat_tcnt", taken_cnt, 15);

        // ---------------- reset in the first flush cycle ----------------
        drive(1'b1, 6'd4, 5'd0, 32'h0, 32'h0, 32'h500, 16'h0001);
        tick();
        in_valid = 1'b0;
        chk("rmf_flush_before", flush, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmf_flush", flush, 0);
        chk("rmf_ready", ready, 1);
        chk("rmf_valid", out_valid, 0);
        chk("rmf_bcnt", branch_cnt, 0);
        chk("rmf_tcnt", taken_cnt, 0);
        chk("rmf_target", target, 0);
        tick();
        chk("rmf_stays_idle", flush, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
